// File: rtl/mux_bus_arbiter.sv
// Round-robin arbiter driving the select and one-hot grant of a shared 32-bit bus mux,
// with a valid/ready burst handshake. Optional stall watchdog: define ARB_WATCHDOG_EN.
module mux_bus_arbiter #(
    parameter int NUM_REQ   = 32,
    parameter int SEL_W     = 5,
    parameter int MAX_BURST = 4
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic [NUM_REQ-1:0] REQ,
    input  logic [NUM_REQ-1:0] LAST,
    input  logic               OUT_READY,
    output logic [SEL_W-1:0]   SEL,
    output logic [NUM_REQ-1:0] GNT,
    output logic               OUT_VALID,
    output logic               BUSY,
    output logic               TIMEOUT
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    // Returns {found, index} of the first set request at or after ptr, wrapping at NUM_REQ.
    function automatic logic [SEL_W:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                               input logic [SEL_W-1:0]   ptr);
        logic             found;
        logic [SEL_W-1:0] pick;
        int               idx;
        found = 1'b0;
        pick  = {SEL_W{1'b0}};
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = int'(ptr) + i;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end else begin
                idx = idx;
            end
            if (!found && 1'(req >> idx)) begin
                found = 1'b1;
                pick  = SEL_W'(idx);
            end else begin
                found = found;
            end
        end
        return {found, pick};
    endfunction

    state_t             state_q, state_d;
    logic [SEL_W-1:0]   ptr_q, ptr_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic               busy_q, busy_d;
    logic [3:0]         cnt_q, cnt_d;

    logic [SEL_W:0]     pick_s;
    logic               req_sel_s;
    logic               last_sel_s;
    logic               valid_s;
    logic               beat_s;
    logic               release_s;
    logic [SEL_W-1:0]   ptr_next_s;

`ifdef ARB_WATCHDOG_EN
    logic [3:0]         stall_q, stall_d;
    logic               timeout_q, timeout_d;
`endif

    assign pick_s     = rr_pick(REQ, ptr_q);
    assign req_sel_s  = 1'(REQ >> sel_q);
    assign last_sel_s = 1'(LAST >> sel_q);
    assign valid_s    = busy_q & req_sel_s;
    assign beat_s     = valid_s & OUT_READY;
    assign ptr_next_s = (sel_q == SEL_W'(NUM_REQ - 1)) ? {SEL_W{1'b0}} : sel_q + SEL_W'(1);

    // Next-state logic: arbitration in IDLE, beat counting and release in GRANT.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        sel_d     = sel_q;
        gnt_d     = gnt_q;
        busy_d    = busy_q;
        cnt_d     = cnt_q;
        release_s = 1'b0;
`ifdef ARB_WATCHDOG_EN
        stall_d   = stall_q;
        timeout_d = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (pick_s[SEL_W]) begin
                    sel_d   = pick_s[SEL_W-1:0];
                    gnt_d   = {{(NUM_REQ-1){1'b0}}, 1'b1} << pick_s[SEL_W-1:0];
                    busy_d  = 1'b1;
                    cnt_d   = 4'd0;
                    state_d = ST_GRANT;
`ifdef ARB_WATCHDOG_EN
                    stall_d = 4'd0;
`endif
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_GRANT: begin
                if (!req_sel_s) begin
                    release_s = 1'b1;
`ifdef ARB_WATCHDOG_EN
                end else if (stall_q == 4'd15) begin
                    // Watchdog release behaves like a withdrawal, flagged by TIMEOUT.
                    release_s = 1'b1;
                    timeout_d = 1'b1;
`endif
                end else if (beat_s) begin
                    cnt_d = cnt_q + 4'd1;
                    if (last_sel_s || (cnt_q + 4'd1 == 4'(MAX_BURST))) begin
                        release_s = 1'b1;
                    end else begin
                        release_s = 1'b0;
                    end
                end else begin
                    release_s = 1'b0;
                end
`ifdef ARB_WATCHDOG_EN
                if (beat_s) begin
                    stall_d = 4'd0;
                end else if (valid_s && !OUT_READY) begin
                    stall_d = stall_q + 4'd1;
                end else begin
                    stall_d = stall_q;
                end
`endif
                if (release_s) begin
                    ptr_d   = ptr_next_s;
                    gnt_d   = {NUM_REQ{1'b0}};
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_GRANT;
                end
            end
            default: begin
                state_d = ST_IDLE;
                gnt_d   = {NUM_REQ{1'b0}};
                busy_d  = 1'b0;
            end
        endcase
    end

    // State registers with synchronous reset; reset abandons any burst in progress.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= ST_IDLE;
            ptr_q     <= {SEL_W{1'b0}};
            sel_q     <= {SEL_W{1'b0}};
            gnt_q     <= {NUM_REQ{1'b0}};
            busy_q    <= 1'b0;
            cnt_q     <= 4'd0;
`ifdef ARB_WATCHDOG_EN
            stall_q   <= 4'd0;
            timeout_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            sel_q     <= sel_d;
            gnt_q     <= gnt_d;
            busy_q    <= busy_d;
            cnt_q     <= cnt_d;
`ifdef ARB_WATCHDOG_EN
            stall_q   <= stall_d;
            timeout_q <= timeout_d;
`endif
        end
    end

    assign SEL       = sel_q;
    assign GNT       = gnt_q;
    assign BUSY      = busy_q;
    assign OUT_VALID = valid_s;
`ifdef ARB_WATCHDOG_EN
    assign TIMEOUT   = timeout_q;
`else
    assign TIMEOUT   = 1'b0;
`endif

endmodule
